// File: rtl/arm_shift_pkg.sv
// Shared definitions for the ARM shifter-operand decoder: shift type codes,
// decoder FSM states, operand forms and instruction field positions.
package arm_shift_pkg;

  typedef enum logic [1:0] {
    ShLsl = 2'b00,
    ShLsr = 2'b01,
    ShAsr = 2'b10,
    ShRor = 2'b11
  } shift_e;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StRsWait = 2'b01,
    StHold   = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    FormImmRot   = 2'b00,  // I=1 rotated 8-bit immediate
    FormImmShift = 2'b01,  // Rm shifted by a 5-bit immediate
    FormRegShift = 2'b10   // Rm shifted by Rs[7:0]
  } form_e;

  localparam int unsigned IBit      = 25;
  localparam int unsigned RegShBit  = 4;
  localparam int unsigned RsLsb     = 8;
  localparam int unsigned RotLsb    = 8;
  localparam int unsigned ShAmtLsb  = 7;
  localparam int unsigned ShTypeLsb = 5;

endpackage

// File: rtl/shift_operand_decoder_if.sv
// Decode-side instruction handshake, Rs register-file read port and the
// shifter command bus. slave = decoder, master = surrounding pipeline.
// Optional forwarding port present when SHDEC_RS_FWD_EN is defined.
interface shift_operand_decoder_if;
  logic [31:0] Instr;
  logic        InstrValid;
  logic        InstrReady;
  logic        RsRdEn;
  logic [3:0]  RsAddr;
  logic [31:0] RsData;
  logic        OutValid;
  logic        OutReady;
  logic [4:0]  Amount;
  logic [1:0]  IR;
  logic        STA;
  logic        EN;
  logic        UseImm;
  logic [31:0] ImmOut;
  logic        Ovf32;
  logic        OvfBig;
  logic        Rrx;
`ifdef SHDEC_RS_FWD_EN
  logic        WbEn;
  logic [3:0]  WbAddr;
  logic [31:0] WbData;
`endif

  modport slave (
    input  Instr, InstrValid, RsData, OutReady,
`ifdef SHDEC_RS_FWD_EN
    input  WbEn, WbAddr, WbData,
`endif
    output InstrReady, RsRdEn, RsAddr, OutValid, Amount, IR, STA, EN, UseImm, ImmOut,
    output Ovf32, OvfBig, Rrx
  );

  modport master (
    output Instr, InstrValid, RsData, OutReady,
`ifdef SHDEC_RS_FWD_EN
    output WbEn, WbAddr, WbData,
`endif
    input  InstrReady, RsRdEn, RsAddr, OutValid, Amount, IR, STA, EN, UseImm, ImmOut,
    input  Ovf32, OvfBig, Rrx
  );
endinterface

// File: rtl/shift_amount_fixup.sv
// Combinational fix-up of a raw shift amount into the shifter's
// Amount/EN controls plus the special-case flags (32, >32, RRX).
module shift_amount_fixup
  import arm_shift_pkg::*;
(
  input  form_e      form,
  input  logic [7:0] raw,
  input  shift_e     typ,
  output logic [4:0] amount,
  output logic       en,
  output logic       ovf32,
  output logic       ovfbig,
  output logic       rrx
);

  // Map operand form and raw amount onto shifter controls
  always_comb begin
    amount = 5'd0;
    en     = 1'b1;
    ovf32  = 1'b0;
    ovfbig = 1'b0;
    rrx    = 1'b0;
    case (form)
      FormImmRot: amount = {raw[3:0], 1'b0};
      FormImmShift: begin
        amount = raw[4:0];
        if (raw[4:0] == 5'd0) begin
          case (typ)
            ShLsl:        en    = 1'b0;
            ShLsr, ShAsr: ovf32 = 1'b1;  // #0 encodes #32
            default:      rrx   = 1'b1;  // ROR #0 encodes RRX
          endcase
        end
      end
      FormRegShift: begin
        if (raw == 8'd0) begin
          en = 1'b0;
        end else if (typ == ShRor) begin
          amount = raw[4:0];
          ovf32  = (raw[4:0] == 5'd0);
        end else if (raw < 8'd32) begin
          amount = raw[4:0];
        end else if (raw == 8'd32) begin
          ovf32 = 1'b1;
        end else begin
          ovfbig = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/shift_operand_decoder.sv
// Decodes the shifter-operand field of an ARM data-processing instruction
// into one registered barrel-shifter command. Rs forms read the register
// file first (RS_LAT cycles). Define SHDEC_RS_FWD_EN to forward a same-cycle
// writeback onto the sampled Rs value.
module shift_operand_decoder
  import arm_shift_pkg::*;
#(
  parameter int unsigned RS_LAT = 1  // legal 1..3
) (
  input logic              Clk,
  input logic              nReset,
  input logic              Flush,
  shift_operand_decoder_if.slave bus
);

  localparam logic [1:0] CntLast = 2'(RS_LAT - 1);

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  shift_e     typ_q, ir_q;
  logic [3:0] rs_addr_q;
  logic [4:0] amount_q;
  logic       sta_q, en_q, use_imm_q, ovf32_q, ovfbig_q, rrx_q;
  logic [7:0] imm_q;

  logic       instr_ready, accept, is_rs, rs_sample, out_valid;
  logic [7:0] rs_byte;
  form_e      fx_form;
  logic [7:0] fx_raw;
  shift_e     fx_type;
  logic [4:0] fx_amount;
  logic       fx_en, fx_ovf32, fx_ovfbig, fx_rrx;
  logic       unused_bits;

  assign is_rs       = ~bus.Instr[IBit] & bus.Instr[RegShBit];
  assign out_valid   = (state_q == StHold);
  assign instr_ready = ~Flush & ((state_q == StIdle) | (out_valid & bus.OutReady));
  assign accept      = instr_ready & bus.InstrValid;
  assign rs_sample   = ~Flush & (state_q == StRsWait) & (cnt_q == CntLast);

`ifdef SHDEC_RS_FWD_EN
  assign rs_byte     = (bus.WbEn && (bus.WbAddr == rs_addr_q)) ? bus.WbData[7:0] : bus.RsData[7:0];
  assign unused_bits = ^{bus.Instr[31:26], bus.Instr[24:12], bus.RsData[31:8], bus.WbData[31:8]};
`else
  assign rs_byte     = bus.RsData[7:0];
  assign unused_bits = ^{bus.Instr[31:26], bus.Instr[24:12], bus.RsData[31:8]};
`endif

  // Fix-up input: the sampled Rs byte while waiting, else the incoming Instr
  always_comb begin
    fx_form = FormImmShift;
    fx_raw  = {3'b000, bus.Instr[ShAmtLsb +: 5]};
    fx_type = shift_e'(bus.Instr[ShTypeLsb +: 2]);
    if (state_q == StRsWait) begin
      fx_form = FormRegShift;
      fx_raw  = rs_byte;
      fx_type = typ_q;
    end else if (bus.Instr[IBit]) begin
      fx_form = FormImmRot;
      fx_raw  = {4'b0000, bus.Instr[RotLsb +: 4]};
      fx_type = ShRor;
    end
  end

  shift_amount_fixup u_fixup (
    .form   (fx_form),
    .raw    (fx_raw),
    .typ    (fx_type),
    .amount (fx_amount),
    .en     (fx_en),
    .ovf32  (fx_ovf32),
    .ovfbig (fx_ovfbig),
    .rrx    (fx_rrx)
  );

  // Next-state logic; Flush overrides every transition
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        cnt_d = 2'd0;
        if (accept) state_d = is_rs ? StRsWait : StHold;
      end
      StRsWait: begin
        if (cnt_q == CntLast) begin
          state_d = StHold;
          cnt_d   = 2'd0;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      StHold: begin
        if (accept)            state_d = is_rs ? StRsWait : StHold;
        else if (bus.OutReady) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (Flush) begin
      state_d = StIdle;
      cnt_d   = 2'd0;
    end
  end

  // FSM state and wait counter
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= StIdle;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Command fields: immediate forms load on accept, Rs forms on the sample cycle
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      typ_q     <= ShLsl;
      rs_addr_q <= 4'd0;
      ir_q      <= ShLsl;
      amount_q  <= 5'd0;
      sta_q     <= 1'b0;
      en_q      <= 1'b0;
      use_imm_q <= 1'b0;
      imm_q     <= 8'd0;
      ovf32_q   <= 1'b0;
      ovfbig_q  <= 1'b0;
      rrx_q     <= 1'b0;
    end else begin
      if (accept) begin
        imm_q     <= bus.Instr[7:0];
        use_imm_q <= bus.Instr[IBit];
        sta_q     <= bus.Instr[IBit];
        if (is_rs) begin
          typ_q     <= shift_e'(bus.Instr[ShTypeLsb +: 2]);
          rs_addr_q <= bus.Instr[RsLsb +: 4];
        end else begin
          ir_q     <= bus.Instr[IBit] ? ShRor : shift_e'(bus.Instr[ShTypeLsb +: 2]);
          amount_q <= fx_amount;
          en_q     <= fx_en;
          ovf32_q  <= fx_ovf32;
          ovfbig_q <= fx_ovfbig;
          rrx_q    <= fx_rrx;
        end
      end
      if (rs_sample) begin
        ir_q     <= typ_q;
        amount_q <= fx_amount;
        en_q     <= fx_en;
        ovf32_q  <= fx_ovf32;
        ovfbig_q <= fx_ovfbig;
        rrx_q    <= fx_rrx;
      end
    end
  end

  assign bus.InstrReady = instr_ready;
  assign bus.RsRdEn     = accept & is_rs;
  // Address goes out with the strobe, then is held until the data is sampled
  assign bus.RsAddr     = (accept & is_rs) ? bus.Instr[RsLsb +: 4] : rs_addr_q;
  assign bus.OutValid   = out_valid;
  assign bus.Amount     = amount_q;
  assign bus.IR         = ir_q;
  assign bus.STA        = sta_q;
  assign bus.EN         = en_q;
  assign bus.UseImm     = use_imm_q;
  assign bus.ImmOut     = {24'd0, imm_q};
  assign bus.Ovf32      = ovf32_q & out_valid;
  assign bus.OvfBig     = ovfbig_q & out_valid;
  assign bus.Rrx        = rrx_q & out_valid;

endmodule

// File: tb/tb_shift_operand_decoder.sv
// Scoreboard bench for shift_operand_decoder (RS_LAT=2).
module tb_shift_operand_decoder;

  localparam int unsigned RsLat = 2;

  logic Clk = 1'b0;
  logic nReset;
  logic Flush;

  shift_operand_decoder_if bus ();

  shift_operand_decoder #(.RS_LAT(RsLat)) dut (
    .Clk    (Clk),
    .nReset (nReset),
    .Flush  (Flush),
    .bus    (bus)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string       name;
    logic [44:0] f;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          nrs = 0;
  int          nrd = 0;
  bit          pending = 1'b0;
  logic [31:0] rf [16];
  logic [4:0]  pipe [RsLat];
  logic [44:0] act_w;

  assign act_w = {bus.Amount, bus.IR, bus.STA, bus.EN, bus.UseImm, bus.ImmOut,
                  bus.Ovf32, bus.OvfBig, bus.Rrx};

  // Register file model: data valid exactly RsLat cycles after the strobe
  always @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < RsLat; i++) pipe[i] <= 5'd0;
    end else begin
      pipe[0] <= {bus.RsRdEn, bus.RsAddr};
      for (int i = 1; i < RsLat; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign bus.RsData = pipe[RsLat-1][4] ? rf[pipe[RsLat-1][3:0]] : 32'hDEAD_BEEF;

  always @(posedge Clk) begin
    cyc <= cyc + 1;
    if (bus.RsRdEn) nrd <= nrd + 1;
  end

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", n, act, exp);
    end
  endtask

  function automatic exp_t mk(input string n, input logic [4:0] am, input logic [1:0] ir,
                              input logic sta, input logic en, input logic ui,
                              input logic [7:0] imm, input logic o32, input logic ob,
                              input logic rx, input int lat);
    exp_t r;
    r.name = n;
    r.f    = {am, ir, sta, en, ui, 24'h0, imm, o32, ob, rx};
    r.lat  = lat;
    r.acc  = 0;
    return r;
  endfunction

  // Monitor: compare the head of the scoreboard whenever a command is presented
  always @(negedge Clk) begin
    if (!nReset) begin
      pending = 1'b0;
    end else if (bus.OutValid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out got=%0h want=none", act_w);
      end else begin
        chk({sb[0].name, "_fields"}, 64'(act_w), 64'(sb[0].f));
        if (!pending) chk({sb[0].name, "_lat"}, 64'(cyc - sb[0].acc), 64'(sb[0].lat));
        pending = 1'b1;
        if (bus.OutReady) begin
          void'(sb.pop_front());
          pending = 1'b0;
        end
      end
    end else begin
      chk("flags_idle", 64'({bus.Ovf32, bus.OvfBig, bus.Rrx}), 64'd0);
    end
  end

  // Present an instruction, wait (bounded) for acceptance, optionally expect a command
  task automatic issue(input logic [31:0] ins, input exp_t e, input bit push);
    int t = 0;
    bus.Instr      = ins;
    bus.InstrValid = 1'b1;
    @(negedge Clk);
    while (!bus.InstrReady && t < 50) begin
      @(negedge Clk);
      t++;
    end
    if (!bus.InstrReady) begin
      checks++;
      failures++;
      $display("FAIL %s_accept got=timeout want=accept", e.name);
    end else begin
      e.acc = cyc;
      if (push) sb.push_back(e);
      if (!ins[25] && ins[4]) nrs++;
    end
    @(posedge Clk);
    #1 bus.InstrValid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge Clk);
      t++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain got=%0d want=0 pending", sb.size());
    end
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 32'h0;
    rf[2] = 32'hABCD_0028;  // 40 -> >32
    rf[3] = 32'h1234_5620;  // 32
    rf[4] = 32'h0000_0040;  // ROR by 64
    rf[5] = 32'hFFFF_FF00;  // zero low byte
    rf[6] = 32'h0000_000D;  // 13
    rf[7] = 32'h0000_0025;  // ROR 37 -> 5
    rf[8] = 32'h0000_001F;  // 31
    nReset         = 1'b0;
    Flush          = 1'b0;
    bus.Instr      = 32'h0;
    bus.InstrValid = 1'b0;
    bus.OutReady   = 1'b1;
`ifdef SHDEC_RS_FWD_EN
    bus.WbEn   = 1'b0;
    bus.WbAddr = 4'd0;
    bus.WbData = 32'h0;
`endif
    #12;
    chk("rst_outvalid", 64'(bus.OutValid), 64'd0);
    chk("rst_instrready", 64'(bus.InstrReady), 64'd1);
    chk("rst_rsrden", 64'(bus.RsRdEn), 64'd0);
    chk("rst_rsaddr", 64'(bus.RsAddr), 64'd0);
    chk("rst_fields", 64'(act_w), 64'd0);
    @(posedge Clk);
    #1 nReset = 1'b1;

    // Immediate forms, back-to-back
    issue(32'hE3A004FF, mk("imm_rot", 5'd8, 2'b11, 1, 1, 1, 8'hFF, 0, 0, 0, 1), 1);
    issue(32'hE1A00021, mk("lsr0", 5'd0, 2'b01, 0, 1, 0, 8'h21, 1, 0, 0, 1), 1);
    issue(32'hE1A00001, mk("lsl0", 5'd0, 2'b00, 0, 0, 0, 8'h01, 0, 0, 0, 1), 1);
    issue(32'hE1A00281, mk("lsl5", 5'd5, 2'b00, 0, 1, 0, 8'h81, 0, 0, 0, 1), 1);
    issue(32'hE1A00061, mk("rrx", 5'd0, 2'b11, 0, 1, 0, 8'h61, 0, 0, 1, 1), 1);
    issue(32'hE1A00FC1, mk("asr31", 5'd31, 2'b10, 0, 1, 0, 8'hC1, 0, 0, 0, 1), 1);

    // Register-specified forms, interleaved with immediates
    issue(32'hE1A00211, mk("rs_lsl40", 5'd0, 2'b00, 0, 1, 0, 8'h11, 0, 1, 0, 3), 1);
    issue(32'hE1A00331, mk("rs_lsr32", 5'd0, 2'b01, 0, 1, 0, 8'h31, 1, 0, 0, 3), 1);
    issue(32'hE1A00281, mk("lsl5_b", 5'd5, 2'b00, 0, 1, 0, 8'h81, 0, 0, 0, 1), 1);
    issue(32'hE1A00471, mk("rs_ror64", 5'd0, 2'b11, 0, 1, 0, 8'h71, 1, 0, 0, 3), 1);
    issue(32'hE1A00571, mk("rs_ror0", 5'd0, 2'b11, 0, 0, 0, 8'h71, 0, 0, 0, 3), 1);
    issue(32'hE1A00651, mk("rs_asr13", 5'd13, 2'b10, 0, 1, 0, 8'h51, 0, 0, 0, 3), 1);
    issue(32'hE1A00771, mk("rs_ror37", 5'd5, 2'b11, 0, 1, 0, 8'h71, 0, 0, 0, 3), 1);
    issue(32'hE1A00831, mk("rs_lsr31", 5'd31, 2'b01, 0, 1, 0, 8'h31, 0, 0, 0, 3), 1);
    drain();

    // Backpressure: command held 4 cycles, then back-to-back accept of an Rs form
    bus.OutReady = 1'b0;
    issue(32'hE1A00FC1, mk("stall_asr31", 5'd31, 2'b10, 0, 1, 0, 8'hC1, 0, 0, 0, 1), 1);
    bus.Instr      = 32'hE1A00211;
    bus.InstrValid = 1'b1;
    repeat (4) begin
      @(negedge Clk);
      chk("stall_instrready", 64'(bus.InstrReady), 64'd0);
    end
    @(posedge Clk);
    #1 bus.OutReady = 1'b1;
    issue(32'hE1A00211, mk("b2b_rs_lsl40", 5'd0, 2'b00, 0, 1, 0, 8'h11, 0, 1, 0, 3), 1);
    drain();

    // Flush mid-RSWAIT: command must vanish; no accept while Flush is high
    issue(32'hE1A00331, mk("flushed", 5'd0, 2'b01, 0, 1, 0, 8'h31, 1, 0, 0, 3), 0);
    Flush          = 1'b1;
    bus.Instr      = 32'hE1A00001;
    bus.InstrValid = 1'b1;
    @(negedge Clk);
    chk("flush_instrready", 64'(bus.InstrReady), 64'd0);
    @(posedge Clk);
    #1 Flush = 1'b0;
    issue(32'hE1A00001, mk("post_flush_lsl0", 5'd0, 2'b00, 0, 0, 0, 8'h01, 0, 0, 0, 1), 1);
    drain();

    // Asynchronous reset while holding a command
    bus.OutReady = 1'b0;
    issue(32'hE1A00061, mk("rst_victim", 5'd0, 2'b11, 0, 1, 0, 8'h61, 0, 0, 1, 1), 1);
    @(negedge Clk);
    @(posedge Clk);
    #1 nReset = 1'b0;
    #1;
    chk("rst_hold_outvalid", 64'(bus.OutValid), 64'd0);
    chk("rst_hold_fields", 64'(act_w), 64'd0);
    chk("rst_hold_instrready", 64'(bus.InstrReady), 64'd1);
    sb.delete();
    @(negedge Clk);
    @(posedge Clk);
    #1 nReset = 1'b1;
    bus.OutReady = 1'b1;
    issue(32'hE3A004FF, mk("post_rst_rot", 5'd8, 2'b11, 1, 1, 1, 8'hFF, 0, 0, 0, 1), 1);

`ifdef SHDEC_RS_FWD_EN
    // Writeback to the same register overrides the read data
    bus.WbEn   = 1'b1;
    bus.WbAddr = 4'd2;
    bus.WbData = 32'hFFFF_FF05;
    issue(32'hE1A00211, mk("fwd_lsl5", 5'd5, 2'b00, 0, 1, 0, 8'h11, 0, 0, 0, 3), 1);
    drain();
    bus.WbEn = 1'b0;
`endif

    drain();
    repeat (4) @(posedge Clk);
    chk("rsrden_pulses", 64'(nrd), 64'(nrs));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
